conv3x3_filter: RTL and testbench

Parametrised 3x3 spatial filter for the camera-to-depth pixel path; the next generation of the fixed Gaussian blur stage. Accepts a raster pixel stream with coordinates. Buffers two lines internally. Applies a per-frame-selectable kernel (bypass, 2-D Gaussian, horizontal 1-2-1, vertical 1-2-1) independently to `NUM_CH` packed channels. Emits the filtered pixel tagged with its centre coordinates. Sits between the camera/SPI pixel source and the stereo matching stage.

---
 rtl/conv3x3_filter_pkg.sv | 23 ++
 rtl/conv3x3_filter_line_store.sv | 58 +++++
 rtl/conv3x3_filter.sv | 185 ++++++++++++++++++
 tb/tb_conv3x3_filter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_filter_pkg.sv
// Shared types and kernel constants for the 3x3 spatial filter.
package filter_pkg;

  typedef enum logic [1:0] {
    BYPASS   = 2'd0,
    GAUSS3   = 2'd1,
    HORIZ121 = 2'd2,
    VERT121  = 2'd3
  } filter_mode_t;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } fsm_state_t;

  // 1-2-1 taps: outer weight 1, centre weight 2 (one left shift)
  localparam int unsigned CentreWeightShift = 1;
  localparam int unsigned GaussShift        = 4;
  localparam int unsigned GaussRound        = 8;
  localparam int unsigned Lin121Shift       = 2;
  localparam int unsigned Lin121Round       = 2;

endpackage

// File: rtl/conv3x3_filter_line_store.sv
// Two line RAMs written by row parity; presents rows v-2, v-1 and v one cycle later.
module dual_line_store #(
  parameter int unsigned HRES  = 1280,
  parameter int unsigned PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] pixel,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic             rd_valid,
  output logic [10:0]      rd_hcount,
  output logic [9:0]       rd_vcount,
  output logic [PIX_W-1:0] row_top,
  output logic [PIX_W-1:0] row_mid,
  output logic [PIX_W-1:0] row_bot
);

  localparam int unsigned AW = (HRES > 1) ? $clog2(HRES) : 1;

  logic [PIX_W-1:0] ram0_q [HRES];
  logic [PIX_W-1:0] ram1_q [HRES];
  logic [PIX_W-1:0] rd0_q, rd1_q;
  logic [AW-1:0]    addr;

  assign addr = hcount[AW-1:0];

  // Reads sample the old word, so the row being overwritten is still row v-2.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (vcount[0]) ram1_q[addr] <= pixel;
      else           ram0_q[addr] <= pixel;
    end
    rd0_q <= ram0_q[addr];
    rd1_q <= ram1_q[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      rd_hcount <= '0;
      rd_vcount <= '0;
      row_bot   <= '0;
    end else begin
      rd_valid <= wr_en;
      if (wr_en) begin
        rd_hcount <= hcount;
        rd_vcount <= vcount;
        row_bot   <= pixel;
      end
    end
  end

  assign row_top = rd_vcount[0] ? rd1_q : rd0_q;
  assign row_mid = rd_vcount[0] ? rd0_q : rd1_q;

endmodule

// File: rtl/conv3x3_filter.sv
// 3x3 per-channel spatial filter with frame-latched kernel select and fixed 4-cycle latency.
module conv3x3_filter
  import filter_pkg::*;
#(
  parameter int unsigned HRES   = 1280,
  parameter int unsigned VRES   = 720,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CH_W   = 8,
  parameter int unsigned PIX_W  = NUM_CH * CH_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [1:0]       mode_in,
  input  logic             data_valid_in,
  input  logic [PIX_W-1:0] pixel_data_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  output logic             data_valid_out,
  output logic [PIX_W-1:0] pixel_data_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic [1:0]       mode_out
);

  function automatic logic [CH_W+1:0] tap121(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b,
                                             input logic [CH_W-1:0] c);
    return {2'b00, a} + ({2'b00, b} << CentreWeightShift) + {2'b00, c};
  endfunction

  fsm_state_t   state_q;
  filter_mode_t mode_q;
  logic         in_range, is_origin, accept;

  assign in_range  = (hcount_in < 11'(HRES)) && (vcount_in < 10'(VRES));
  assign is_origin = data_valid_in && in_range && (hcount_in == '0) && (vcount_in == '0);
  assign accept    = data_valid_in && in_range && ((state_q == ACTIVE) || is_origin);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= SYNC;
      mode_q  <= BYPASS;
    end else begin
      unique case (state_q)
        SYNC: if (is_origin) begin
          state_q <= ACTIVE;
          mode_q  <= filter_mode_t'(mode_in);
        end
        ACTIVE: if (is_origin) mode_q <= filter_mode_t'(mode_in);
        default: state_q <= SYNC;
      endcase
    end
  end

  // Stage 1: line store read
  logic             s1_valid;
  logic [10:0]      s1_h;
  logic [9:0]       s1_v;
  logic [PIX_W-1:0] s1_top, s1_mid, s1_bot;
  filter_mode_t     s1_mode_q;

  dual_line_store #(
    .HRES  (HRES),
    .PIX_W (PIX_W)
  ) u_line_store (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .wr_en     (accept),
    .pixel     (pixel_data_in),
    .hcount    (hcount_in),
    .vcount    (vcount_in),
    .rd_valid  (s1_valid),
    .rd_hcount (s1_h),
    .rd_vcount (s1_v),
    .row_top   (s1_top),
    .row_mid   (s1_mid),
    .row_bot   (s1_bot)
  );

  // Stage 2: window columns [0]=h-2, [1]=h-1, [2]=h; rows [0]=v-2, [1]=v-1, [2]=v
  logic [2:0][PIX_W-1:0] win_q [3];
  logic                  s2_valid_q;
  logic [10:0]           s2_h_q;
  logic [9:0]            s2_v_q;
  filter_mode_t          s2_mode_q;

  always_ff @(posedge clk_in) begin
    if (s1_valid) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= {s1_bot, s1_mid, s1_top};
    end
  end

  // Stage 3 control: only centres with h>=1, v>=1 go on to the output
  logic         s3_valid_q, s3_border_q;
  logic [10:0]  s3_h_q;
  logic [9:0]   s3_v_q;
  filter_mode_t s3_mode_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_mode_q   <= BYPASS;
      s2_valid_q  <= 1'b0;
      s2_h_q      <= '0;
      s2_v_q      <= '0;
      s2_mode_q   <= BYPASS;
      s3_valid_q  <= 1'b0;
      s3_border_q <= 1'b0;
      s3_h_q      <= '0;
      s3_v_q      <= '0;
      s3_mode_q   <= BYPASS;
    end else begin
      if (accept) s1_mode_q <= mode_q;
      s2_valid_q <= s1_valid;
      if (s1_valid) begin
        s2_h_q    <= s1_h;
        s2_v_q    <= s1_v;
        s2_mode_q <= s1_mode_q;
      end
      s3_valid_q <= s2_valid_q && (s2_h_q != '0) && (s2_v_q != '0);
      if (s2_valid_q) begin
        s3_h_q      <= s2_h_q - 11'd1;
        s3_v_q      <= s2_v_q - 10'd1;
        s3_border_q <= (s2_h_q == 11'd1) || (s2_v_q == 10'd1);
        s3_mode_q   <= s2_mode_q;
      end
    end
  end

  logic [PIX_W-1:0] filt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CH_W+1:0] rsum_q [3];
    logic [CH_W+1:0] vsum_q;
    logic [CH_W-1:0] ctr_q;
    logic [CH_W-1:0] res;

    always_ff @(posedge clk_in) begin
      if (s2_valid_q) begin
        for (int r = 0; r < 3; r++) begin
          rsum_q[r] <= tap121(win_q[0][r][c*CH_W +: CH_W], win_q[1][r][c*CH_W +: CH_W],
                              win_q[2][r][c*CH_W +: CH_W]);
        end
        vsum_q <= tap121(win_q[1][0][c*CH_W +: CH_W], win_q[1][1][c*CH_W +: CH_W],
                         win_q[1][2][c*CH_W +: CH_W]);
        ctr_q  <= win_q[1][1][c*CH_W +: CH_W];
      end
    end

    // Stage 4 arithmetic; sums are sized so the rounded result always fits CH_W
    always_comb begin
      res = ctr_q;
      if (!s3_border_q) begin
        unique case (s3_mode_q)
          GAUSS3:   res = CH_W'(({2'b00, rsum_q[0]} + ({2'b00, rsum_q[1]} << CentreWeightShift)
                                 + {2'b00, rsum_q[2]} + (CH_W+4)'(GaussRound)) >> GaussShift);
          HORIZ121: res = CH_W'((rsum_q[1] + (CH_W+2)'(Lin121Round)) >> Lin121Shift);
          VERT121:  res = CH_W'((vsum_q + (CH_W+2)'(Lin121Round)) >> Lin121Shift);
          default:  res = ctr_q;
        endcase
      end
    end

    assign filt[c*CH_W +: CH_W] = res;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      mode_out       <= '0;
    end else begin
      data_valid_out <= s3_valid_q;
      if (s3_valid_q) begin
        pixel_data_out <= filt;
        hcount_out     <= s3_h_q;
        vcount_out     <= s3_v_q;
        mode_out       <= s3_mode_q;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Random-stimulus bench for conv3x3_filter against a frame-array reference model.
module tb_conv3x3_filter;

  localparam int unsigned HRES   = 8;
  localparam int unsigned VRES   = 6;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned PIX_W  = NUM_CH * CH_W;

  logic             clk = 1'b0;
  logic             rst_n_in = 1'b1;
  logic [1:0]       mode_in = '0;
  logic             data_valid_in = 1'b0;
  logic [PIX_W-1:0] pixel_data_in = '0;
  logic [10:0]      hcount_in = '0;
  logic [9:0]       vcount_in = '0;
  logic             data_valid_out;
  logic [PIX_W-1:0] pixel_data_out;
  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic [1:0]       mode_out;

  always #5 clk = ~clk;

  conv3x3_filter #(
    .HRES   (HRES),
    .VRES   (VRES),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n_in),
    .mode_in        (mode_in),
    .data_valid_in  (data_valid_in),
    .pixel_data_in  (pixel_data_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_out (data_valid_out),
    .pixel_data_out (pixel_data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .mode_out       (mode_out)
  );

  typedef struct {
    int               due;
    logic [PIX_W-1:0] pix;
    int               h;
    int               v;
    int               mode;
  } exp_t;

  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;
  exp_t             exp_q[$];
  exp_t             last_exp;
  logic [PIX_W-1:0] img_in [VRES][HRES];
  logic [PIX_W-1:0] m_img  [VRES][HRES];
  logic [PIX_W-1:0] cap    [VRES][HRES];
  bit               m_active = 1'b0;
  int               m_mode = 0;
  bit               chk_const = 1'b0;
  int               strobes = 0;
  int               const_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  function automatic int chan(int v, int h, int c);
    return int'(m_img[v][h][c*CH_W +: CH_W]);
  endfunction

  // Reference: weighted neighbourhood sums straight from the kernel definitions.
  function automatic logic [PIX_W-1:0] model_pix(int hc, int vc, int mode);
    logic [PIX_W-1:0] r;
    int w[3] = '{1, 2, 1};
    int s;
    if (hc == 0 || vc == 0 || mode == 0) return m_img[vc][hc];
    r = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      s = 0;
      case (mode)
        1: begin
          for (int dv = -1; dv <= 1; dv++)
            for (int dh = -1; dh <= 1; dh++)
              s += w[dv+1] * w[dh+1] * chan(vc + dv, hc + dh, c);
          s = (s + 8) / 16;
        end
        2: begin
          for (int dh = -1; dh <= 1; dh++) s += w[dh+1] * chan(vc, hc + dh, c);
          s = (s + 2) / 4;
        end
        default: begin
          for (int dv = -1; dv <= 1; dv++) s += w[dv+1] * chan(vc + dv, hc, c);
          s = (s + 2) / 4;
        end
      endcase
      r[c*CH_W +: CH_W] = CH_W'(s);
    end
    return r;
  endfunction

  function automatic void model_accept(int h, int v, logic [PIX_W-1:0] p, int m);
    exp_t e;
    if (h == 0 && v == 0) begin
      m_active = 1'b1;
      m_mode   = m;
    end
    if (!m_active) return;
    m_img[v][h] = p;
    if (h >= 1 && v >= 1) begin
      e.due  = cyc + 4;
      e.pix  = model_pix(h - 1, v - 1, m_mode);
      e.h    = h - 1;
      e.v    = v - 1;
      e.mode = m_mode;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void clear_last();
    last_exp.due  = 0;
    last_exp.pix  = '0;
    last_exp.h    = 0;
    last_exp.v    = 0;
    last_exp.mode = 0;
  endfunction

  task automatic drive(input bit valid, input int h, input int v, input logic [PIX_W-1:0] p,
                       input int m);
    @(posedge clk);
    #1;
    data_valid_in = valid;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    pixel_data_in = p;
    mode_in       = 2'(m);
    if (valid && rst_n_in) model_accept(h, v, p, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, $urandom_range(HRES - 1), $urandom_range(VRES - 1), PIX_W'($urandom()),
            $urandom_range(3));
  endtask

  // mode_rest < 0 drives random mode_in on every pixel except (0,0)
  task automatic send_frame(input int mode0, input int mode_rest, input bit gaps, input int npix);
    int k = 0;
    for (int v = 0; v < int'(VRES); v++) begin
      for (int h = 0; h < int'(HRES); h++) begin
        if (k == npix) return;
        drive(1'b1, h, v, img_in[v][h], (h == 0 && v == 0) ? mode0 :
              ((mode_rest < 0) ? int'($urandom_range(3)) : mode_rest));
        k++;
        if (gaps) idle(1);
      end
    end
  endtask

  task automatic fill_random();
    for (int v = 0; v < int'(VRES); v++)
      for (int h = 0; h < int'(HRES); h++) img_in[v][h] = PIX_W'($urandom());
  endtask

  task automatic fill_const(input logic [PIX_W-1:0] p);
    for (int v = 0; v < int'(VRES); v++)
      for (int h = 0; h < int'(HRES); h++) img_in[v][h] = p;
  endtask

  task automatic impulse_frame(input logic [CH_W-1:0] val, input int ch, input logic [PIX_W-1:0] ctr,
                               input logic [PIX_W-1:0] edg, input logic [PIX_W-1:0] cor);
    logic [PIX_W-1:0] e;
    fill_const('0);
    img_in[3][4] = PIX_W'(val) << (ch * CH_W);
    send_frame(1, -1, 1'b0, HRES * VRES);
    idle(6);
    for (int dv = -1; dv <= 1; dv++) begin
      for (int dh = -1; dh <= 1; dh++) begin
        e = (dv == 0 && dh == 0) ? ctr : ((dv == 0 || dh == 0) ? edg : cor);
        chk("impulse_dut", cap[3+dv][4+dh], e);
        chk("impulse_model", model_pix(4 + dh, 3 + dv, 1), e);
      end
    end
    chk("impulse_far", cap[1][1], '0);
    chk("impulse_far2", cap[4][6], '0);
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #3;
    rst_n_in      = 1'b0;
    data_valid_in = 1'b0;
    exp_q.delete();
    m_active = 1'b0;
    clear_last();
    #1;
    chk("midrst_valid", data_valid_out, 0);
    chk("midrst_pixel", pixel_data_out, 0);
    chk("midrst_hcount", hcount_out, 0);
    chk("midrst_vcount", vcount_out, 0);
    chk("midrst_mode", mode_out, 0);
    idle(2);
    @(posedge clk);
    #1;
    rst_n_in = 1'b1;
  endtask

  // Every cycle: strobe must match the model, and all held outputs must equal the last expectation.
  always @(posedge clk) begin
    #2;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      chk("missed_output_due", exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      last_exp = exp_q.pop_front();
      chk("data_valid_out", data_valid_out, 1);
    end else begin
      chk("data_valid_out", data_valid_out, 0);
    end
    chk("pixel_data_out", pixel_data_out, last_exp.pix);
    chk("hcount_out", hcount_out, last_exp.h);
    chk("vcount_out", vcount_out, last_exp.v);
    chk("mode_out", mode_out, last_exp.mode);
    if (data_valid_out === 1'b1) begin
      strobes++;
      if (hcount_out < HRES && vcount_out < VRES) cap[vcount_out][hcount_out] = pixel_data_out;
      if (chk_const && pixel_data_out !== 24'h646464) const_bad++;
    end
  end

  initial begin
    clear_last();
    #1;
    rst_n_in = 1'b0;
    idle(3);
    chk("reset_valid", data_valid_out, 0);
    chk("reset_pixel", pixel_data_out, 0);
    chk("reset_hcount", hcount_out, 0);
    chk("reset_vcount", vcount_out, 0);
    chk("reset_mode", mode_out, 0);
    @(posedge clk);
    #1;
    rst_n_in = 1'b1;

    // Still in SYNC: valid inputs away from (0,0) must be ignored
    for (int h = 1; h < int'(HRES); h++) drive(1'b1, h, 2, PIX_W'($urandom()), 1);
    idle(6);

    fill_const(24'h646464);
    strobes   = 0;
    const_bad = 0;
    chk_const = 1'b1;
    send_frame(1, -1, 1'b0, HRES * VRES);
    idle(6);
    chk_const = 1'b0;
    chk("const_count", strobes, (HRES - 1) * (VRES - 1));
    chk("const_bad_pixels", const_bad, 0);

    impulse_frame(8'h40, 0, 24'h000010, 24'h000008, 24'h000004);
    impulse_frame(8'hFF, 1, 24'h004000, 24'h002000, 24'h001000);

    fill_random();
    send_frame(0, -1, 1'b1, HRES * VRES);
    idle(6);

    // Mode change away from (0,0) is ignored; the next frame picks it up.
    fill_random();
    send_frame(0, 1, 1'b0, HRES * VRES);
    idle(5);
    chk("switch_stays_bypass", cap[2][3], img_in[2][3]);
    fill_random();
    send_frame(1, 1, 1'b0, HRES * VRES);
    idle(6);
    chk("switch_mode_out", mode_out, 1);

    fill_random();
    send_frame(2, -1, 1'b0, HRES * VRES);
    idle(6);
    for (int v = 0; v < int'(VRES) - 1; v++) chk("horiz_border_col0", cap[v][0], img_in[v][0]);
    for (int h = 1; h < int'(HRES) - 1; h++) chk("horiz_border_row0", cap[0][h], img_in[0][h]);

    fill_random();
    send_frame(3, -1, 1'b1, HRES * VRES);
    idle(6);

    fill_random();
    send_frame(1, -1, 1'b0, 2 * HRES + 4);
    async_reset_mid();
    for (int h = 4; h < int'(HRES); h++) drive(1'b1, h, 2, PIX_W'($urandom()), 2);
    idle(6);
    fill_random();
    send_frame(1, -1, 1'b1, HRES * VRES);
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
